// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin packet arbiter that owns the select and enable of a shared
// N:1 data mux. A grant is held for a whole packet. The next requester in round-robin
// order takes over on the final beat, with no idle cycle between packets.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req[N]            requester i has a valid beat
//   last[N]           requester i's current beat ends its packet
//   data[N*W]         flattened beats, requester i at [i*W +: W]
//   gnt[N]            registered one-hot grant, zero when idle
//   rdy[N]            per-requester ready (gnt & out_ready)
//   sel[SW], en       registered mux select / enable
//   out_data/valid/last, out_ready   downstream valid/ready channel
//   trunc             one-cycle pulse after a packet is force-released at MAX_BEATS
module rr_mux_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned SW        = 2,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rdy,
  output logic [SW-1:0]  sel,
  output logic           en,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic           trunc
);

  localparam int unsigned CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] CntMax = CW'(MAX_BEATS - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic          r_en, w_en_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_trunc, w_trunc_nxt;

  logic          w_cnt_max;
  logic          w_forced;
  logic          w_xfer;
  logic          w_final;
  logic [SW-1:0] w_base;
  logic          w_found;
  logic [SW-1:0] w_win;

  assign w_cnt_max = (r_cnt == CntMax);
  assign w_forced  = r_en & w_cnt_max & ~last[r_sel];
  assign out_valid = r_en & req[r_sel];
  assign out_last  = r_en & (last[r_sel] | w_forced);
  assign out_data  = r_en ? data[r_sel*W +: W] : '0;
  assign w_xfer    = out_valid & out_ready;
  assign w_final   = w_xfer & (last[r_sel] | w_cnt_max);

  assign gnt   = r_gnt;
  assign rdy   = r_gnt & {N{out_ready}};
  assign sel   = r_sel;
  assign en    = r_en;
  assign trunc = r_trunc;

  // Scan base+1 .. base+N (mod N). While busy the base is the current owner and the last
  // step (the owner itself) is skipped, so the owner cannot re-win on its own final beat.
  always_comb begin
    w_base  = (r_state == StBusy) ? r_sel : r_ptr;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[w_base + SW'(k)] && (k < N || r_state == StIdle)) begin
        w_found = 1'b1;
        w_win   = w_base + SW'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_en_nxt    = r_en;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = 1'b0;
    if (r_state == StIdle) begin
      if (w_found) begin
        w_state_nxt = StBusy;
        w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_win;
        w_sel_nxt   = w_win;
        w_en_nxt    = 1'b1;
        w_cnt_nxt   = '0;
      end
    end else if (w_final) begin
      w_ptr_nxt   = r_sel;
      w_trunc_nxt = w_forced;
      w_cnt_nxt   = '0;
      if (w_found) begin
        w_gnt_nxt = {{(N-1){1'b0}}, 1'b1} << w_win;
        w_sel_nxt = w_win;
      end else begin
        w_state_nxt = StIdle;
        w_gnt_nxt   = '0;
        w_sel_nxt   = '0;
        w_en_nxt    = 1'b0;
      end
    end else if (w_xfer) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_ptr   <= SW'(N - 1);
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trunc <= w_trunc_nxt;
    end
  end

endmodule
